inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch side (PC generator plus instruction memory return) and the decode stage. It buffers up to DEPTH fetched {pc, inst} pairs so that a decode stall does not drop in-flight fetches. It generates an early stall request toward the PC stage's pause[0] input. It discards all contents on a branch redirect flush.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; asynchronous and active-low
- flush_i  in  1  branch redirect; empties the queue
- push_valid_i  in  1  fetch side presents a valid {pc, inst}
- push_pc_i  in  ADDR_W  PC of the fetched instruction
- push_inst_i  in  INST_W  fetched instruction word
- push_ready_o  out  1  queue can accept a push (not full)
- stall_req_o  out  1  almost-full; drives the PC stage's pause[0]
- pop_valid_o  out  1  head entry valid (not empty)
- pop_pc_o  out  ADDR_W  head PC
- pop_inst_o  out  INST_W  head instruction
- pop_ready_i  in  1  decode accepts the head entry
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State:
  - storage array mem[DEPTH] of {pc, inst}
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH
  - count register, $clog2(DEPTH)+1 bits
- Handshakes:
  - push = push_valid_i & push_ready_o
  - pop = pop_valid_o & pop_ready_i
- Derived outputs, all decoded from registered count only:
  - push_ready_o = (count != DEPTH)
  - pop_valid_o = (count != 0)
  - stall_req_o = (count >= DEPTH-1)
  - count_o = count
- No combinational path from pop_ready_i to push_ready_o. When full, a same-cycle pop does not make room for a same-cycle push.
- Head data:
  - pop_pc_o/pop_inst_o = mem[rd_ptr] when count != 0
  - both are forced to 0 when empty
- Push: write mem[wr_ptr] <= {push_pc_i, push_inst_i}, then wr_ptr += 1.
- Pop: rd_ptr += 1.
- Count update:
  - push only: count + 1
  - pop only: count - 1
  - both: unchanged
- No fall-through: a push into an empty queue is not visible on pop outputs in the same cycle.
- Flush has the highest priority. When flush_i=1 at an edge:
  - wr_ptr, rd_ptr and count all become 0
  - any same-cycle push or pop is discarded; the pushed entry is not stored
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count become 0
  - storage is not reset
  - outputs during and after reset: pop_valid_o=0, push_ready_o=1, stall_req_o=0, count_o=0, pop_pc_o=0, pop_inst_o=0
  - reset asserted mid-operation drops all entries immediately, without waiting for a clock edge

## Timing
- Push-to-pop latency is 1 cycle: an entry pushed at edge N is presented with pop_valid_o=1 after edge N.
- Throughput is one push and one pop per cycle sustained when 0 < count < DEPTH.
- stall_req_o rises once count reaches DEPTH-1. This leaves one slot for the fetch already in flight while the PC stage holds its pc_o.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling. Ordering is strict FIFO across the wrap.
- Full (count=DEPTH): push_ready_o=0. A push_valid_i asserted while full is ignored, and the fetch side must hold its data.
- Empty (count=0): pop_ready_i is ignored, with no underflow.
- Flush recovery: after a flush edge, push_ready_o=1 and pop_valid_o=0. The first post-flush push is accepted in the next cycle.

## Test plan
- Reset then fill: release rst, push pc=0x0/0x4/0x8/0xC with inst=0x1000_0000+pc and pop_ready_i=0.
  - count_o goes 1,2,3,4
  - stall_req_o=1 from count=3
  - push_ready_o=0 at count=4
  - a 5th push of pc=0x10 is not accepted
- Drain order: from full, hold pop_ready_i=1.
  - heads appear in order pc 0x0,0x4,0x8,0xC over 4 cycles
  - pop_valid_o=0 and pop_pc_o=0 afterwards
- Simultaneous push/pop with wrap: stream 12 sequential PCs starting at 0x1C000000 with both sides always ready.
  - count_o holds at 1
  - outputs appear in strict order across the pointer wrap
- Full plus same-cycle pop/push: at count=4, assert pop_ready_i=1 and push_valid_i=1 with pc=0x10.
  - pop occurs; push is not accepted
  - count_o=3 next cycle
- Flush: at count=3, assert flush_i together with push_valid_i (pc=0x20) and pop_ready_i.
  - next cycle count_o=0, pop_valid_o=0
  - a following push of pc=0x80 is the first entry popped
- Async reset mid-stream: drop rst between clock edges at count=2.
  - count_o=0, pop_valid_o=0 and push_ready_o=1 immediately, without waiting for an edge

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst}
// pairs with an almost-full stall request toward the PC stage and a redirect flush.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_valid_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    output logic              push_ready_o,
    output logic              stall_req_o,
    output logic              pop_valid_o,
    output logic [ADDR_W-1:0] pop_pc_o,
    output logic [INST_W-1:0] pop_inst_o,
    input  logic              pop_ready_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int ENTRY_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Status flags come only from the registered count, so pop_ready_i never
    // reaches push_ready_o combinationally; a pop while full frees no slot this cycle.
    assign push_ready_o = (count_q != FULL_CNT);
    assign pop_valid_o  = (count_q != '0);
    assign stall_req_o  = (count_q >= ALMOST_CNT);
    assign count_o      = count_q;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    always_comb begin
        if (pop_valid_o) begin
            {pop_pc_o, pop_inst_o} = mem[rd_ptr_q];
        end else begin
            pop_pc_o   = '0;
            pop_inst_o = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem[wr_ptr_q] <= {push_pc_i, push_inst_i};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected entries into a queue,
// a monitor compares the head and status outputs every cycle.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic [31:0] push_pc_i = '0;
    logic [31:0] push_inst_i = '0;
    logic        push_ready_o;
    logic        stall_req_o;
    logic        pop_valid_o;
    logic [31:0] pop_pc_o;
    logic [31:0] pop_inst_o;
    logic        pop_ready_i = 1'b0;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;
    int model_count = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_pc_i    (push_pc_i),
        .push_inst_i  (push_inst_i),
        .push_ready_o (push_ready_o),
        .stall_req_o  (stall_req_o),
        .pop_valid_o  (pop_valid_o),
        .pop_pc_o     (pop_pc_o),
        .pop_inst_o   (pop_inst_o),
        .pop_ready_i  (pop_ready_i),
        .count_o      (count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model at the edge.
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
        bit acc_push, acc_pop;
        @(negedge clk);
        #1;
        push_valid_i = pv;
        push_pc_i    = pc;
        push_inst_i  = 32'h1000_0000 + pc;
        pop_ready_i  = pr;
        flush_i      = fl;
        @(posedge clk);
        acc_push = pv && (model_count != DEPTH) && !fl;
        acc_pop  = pr && (model_count != 0) && !fl;
        if (fl) begin
            model_count = 0;
            sb.delete();
        end else begin
            if (acc_push) sb.push_back({pc, 32'h1000_0000 + pc});
            model_count = model_count + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
        end
        $display("cycle: push=%0b pc=%08h pop=%0b flush=%0b -> model count %0d",
                 pv, pc, pr, fl, model_count);
    endtask

    task automatic expect_cnt(input string name, input int exp);
        #1;
        chk(name, 64'(count_o), 64'(exp));
    endtask

    // Monitor: compare status and head with the model/scoreboard mid-cycle.
    always @(negedge clk) begin
        #3;
        chk("mon_count", 64'(count_o), 64'(model_count));
        chk("mon_push_ready", 64'(push_ready_o), 64'(model_count != DEPTH));
        chk("mon_pop_valid", 64'(pop_valid_o), 64'(model_count != 0));
        chk("mon_stall", 64'(stall_req_o), 64'(model_count >= DEPTH - 1));
        if (pop_valid_o) begin
            if (sb.size() == 0) begin
                chk("mon_head_unexpected", {pop_pc_o, pop_inst_o}, 64'hDEAD);
            end else begin
                chk("mon_head", {pop_pc_o, pop_inst_o}, sb[0]);
                if (pop_ready_i && !flush_i && rst) begin
                    $display("pop: pc=%08h inst=%08h", pop_pc_o, pop_inst_o);
                    void'(sb.pop_front());
                end
            end
        end else begin
            chk("mon_head_zero", {pop_pc_o, pop_inst_o}, 64'h0);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Fill with decode stalled; 5th push must be refused.
        cycle(1, 32'h0, 0, 0);  expect_cnt("fill_cnt1", 1);
        chk("fill_stall_at1", 64'(stall_req_o), 64'd0);
        cycle(1, 32'h4, 0, 0);  expect_cnt("fill_cnt2", 2);
        cycle(1, 32'h8, 0, 0);  expect_cnt("fill_cnt3", 3);
        chk("fill_stall_at3", 64'(stall_req_o), 64'd1);
        cycle(1, 32'hC, 0, 0);  expect_cnt("fill_cnt4", 4);
        chk("fill_ready_full", 64'(push_ready_o), 64'd0);
        cycle(1, 32'h10, 0, 0); expect_cnt("fill_overflow", 4);

        // Drain in order.
        chk("drain_head0", 64'(pop_pc_o), 64'h0);
        cycle(0, 0, 1, 0); expect_cnt("drain_cnt3", 3);
        chk("drain_head1", 64'(pop_pc_o), 64'h4);
        cycle(0, 0, 1, 0); expect_cnt("drain_cnt2", 2);
        cycle(0, 0, 1, 0); expect_cnt("drain_cnt1", 1);
        chk("drain_head3", 64'(pop_pc_o), 64'hC);
        cycle(0, 0, 1, 0); expect_cnt("drain_cnt0", 0);
        chk("drain_empty_pc", 64'(pop_pc_o), 64'h0);
        cycle(0, 0, 1, 0); expect_cnt("underflow_cnt", 0);

        // Streaming push+pop across the pointer wrap.
        for (int i = 0; i < 12; i++) begin
            cycle(1, 32'h1C00_0000 + 32'(4 * i), 1, 0);
            expect_cnt("stream_cnt", 1);
        end
        chk("stream_last_head", 64'(pop_pc_o), 64'h1C00_002C);
        cycle(0, 0, 1, 0); expect_cnt("stream_drain", 0);

        // Full with same-cycle pop and push: push refused.
        for (int i = 0; i < 4; i++) cycle(1, 32'h40 + 32'(4 * i), 0, 0);
        expect_cnt("full_again", 4);
        cycle(1, 32'h10, 1, 0); expect_cnt("full_poppush_cnt", 3);
        chk("full_poppush_head", 64'(pop_pc_o), 64'h44);

        // Flush with concurrent push and pop.
        cycle(1, 32'h20, 1, 1); expect_cnt("flush_cnt", 0);
        chk("flush_valid", 64'(pop_valid_o), 64'd0);
        chk("flush_ready", 64'(push_ready_o), 64'd1);
        cycle(1, 32'h80, 0, 0); expect_cnt("post_flush_cnt", 1);
        chk("post_flush_head", 64'(pop_pc_o), 64'h80);
        cycle(0, 0, 1, 0); expect_cnt("post_flush_drain", 0);

        // Asynchronous reset between edges.
        cycle(1, 32'h100, 0, 0);
        cycle(1, 32'h104, 0, 0); expect_cnt("pre_reset_cnt", 2);
        #1;
        rst = 1'b0;
        model_count = 0;
        sb.delete();
        #1;
        chk("areset_cnt", 64'(count_o), 64'd0);
        chk("areset_valid", 64'(pop_valid_o), 64'd0);
        chk("areset_ready", 64'(push_ready_o), 64'd1);
        chk("areset_pc", 64'(pop_pc_o), 64'd0);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        cycle(1, 32'h200, 0, 0); expect_cnt("after_reset_push", 1);
        cycle(0, 0, 1, 0);       expect_cnt("after_reset_pop", 0);
        cycle(0, 0, 0, 0);

        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
